// File: rtl/pixel_dvp_tx.sv
// Pixel stream to DVP transmitter: frames an upstream valid/ready pixel stream
// into VSYNC/HREF timing with fixed sync, porch and blanking intervals.
module pixel_dvp_tx #(
  parameter int GS_PXL_W  = 8,
  parameter int COL_NUM   = 640,
  parameter int ROW_NUM   = 480,
  parameter int VSYNC_CYC = 16,
  parameter int VBP_CYC   = 32,
  parameter int HBLK_CYC  = 144,
  parameter int VFP_CYC   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [GS_PXL_W-1:0] src_pxl_i,
  input  logic                src_pxl_vld_i,
  output logic                src_pxl_rdy_o,
  output logic                dvp_vsync_o,
  output logic                dvp_href_o,
  output logic [GS_PXL_W-1:0] dvp_d_o,
  output logic                frame_done_o,
  output logic                underrun_o
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(max_of(COL_NUM, VSYNC_CYC), max_of(VBP_CYC, HBLK_CYC)), VFP_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int ROW_W   = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLK, VFP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row;
  logic             cnt_tc;

  // cnt is a down-counter loaded with (length-1) on state entry
  assign cnt_tc        = (cnt == '0);
  assign src_pxl_rdy_o = (state == ACTIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      row          <= '0;
      dvp_vsync_o  <= 1'b0;
      dvp_href_o   <= 1'b0;
      dvp_d_o      <= '0;
      frame_done_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      dvp_vsync_o  <= (state == VSYNC);
      dvp_href_o   <= (state == ACTIVE);
      dvp_d_o      <= (state == ACTIVE && src_pxl_vld_i) ? src_pxl_i : '0;
      frame_done_o <= 1'b0;
      if (state == ACTIVE && !src_pxl_vld_i) underrun_o <= 1'b1;

      case (state)
        IDLE: begin
          if (en_i) begin
            state      <= VSYNC;
            cnt        <= CNT_W'(VSYNC_CYC - 1);
            underrun_o <= 1'b0;
          end
        end
        VSYNC: begin
          if (cnt_tc) begin
            state <= VBP;
            cnt   <= CNT_W'(VBP_CYC - 1);
          end else cnt <= cnt - CNT_W'(1);
        end
        VBP: begin
          if (cnt_tc) begin
            state <= ACTIVE;
            cnt   <= CNT_W'(COL_NUM - 1);
            row   <= '0;
          end else cnt <= cnt - CNT_W'(1);
        end
        ACTIVE: begin
          if (cnt_tc) begin
            if (row == ROW_W'(ROW_NUM - 1)) begin
              state <= VFP;
              cnt   <= CNT_W'(VFP_CYC - 1);
            end else begin
              state <= HBLK;
              cnt   <= CNT_W'(HBLK_CYC - 1);
            end
          end else cnt <= cnt - CNT_W'(1);
        end
        HBLK: begin
          if (cnt_tc) begin
            state <= ACTIVE;
            cnt   <= CNT_W'(COL_NUM - 1);
            row   <= row + ROW_W'(1);
          end else cnt <= cnt - CNT_W'(1);
        end
        VFP: begin
          if (cnt_tc) begin
            frame_done_o <= 1'b1;
            // en_i only matters here and in IDLE, so frames are never truncated
            if (en_i) begin
              state      <= VSYNC;
              cnt        <= CNT_W'(VSYNC_CYC - 1);
              underrun_o <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else cnt <= cnt - CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_dvp_tx.sv
// Bench for pixel_dvp_tx: random valid/enable stimulus checked every cycle
// against a frame-position model of the DVP timing.
module tb_pixel_dvp_tx;
  localparam int PW    = 8;
  localparam int COL   = 4;
  localparam int ROW   = 2;
  localparam int VS    = 2;
  localparam int VBP   = 3;
  localparam int HB    = 2;
  localparam int VFP   = 3;
  localparam int FRAME = VS + VBP + ROW*COL + (ROW-1)*HB + VFP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_i = 1'b0;
  logic [PW-1:0] src_pxl_i = '0;
  logic          src_pxl_vld_i = 1'b0;
  logic          src_pxl_rdy_o;
  logic          dvp_vsync_o;
  logic          dvp_href_o;
  logic [PW-1:0] dvp_d_o;
  logic          frame_done_o;
  logic          underrun_o;

  pixel_dvp_tx #(
    .GS_PXL_W(PW), .COL_NUM(COL), .ROW_NUM(ROW), .VSYNC_CYC(VS),
    .VBP_CYC(VBP), .HBLK_CYC(HB), .VFP_CYC(VFP)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .src_pxl_i(src_pxl_i),
    .src_pxl_vld_i(src_pxl_vld_i), .src_pxl_rdy_o(src_pxl_rdy_o),
    .dvp_vsync_o(dvp_vsync_o), .dvp_href_o(dvp_href_o), .dvp_d_o(dvp_d_o),
    .frame_done_o(frame_done_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  // model: position within the frame the DUT is in during the current cycle
  bit            m_busy = 1'b0;
  int            m_pos  = 0;
  bit            m_und  = 1'b0;
  logic [PW-1:0] next_pix = 8'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_active(input int pos);
    int a;
    a = pos - VS - VBP;
    if (a < 0 || a >= ROW*COL + (ROW-1)*HB) return 1'b0;
    return (a % (COL + HB)) < COL;
  endfunction

  task automatic cycle(input bit en, input bit vld);
    bit            act;
    bit            e_vs;
    bit            e_fd;
    logic [PW-1:0] e_d;
    @(negedge clk);
    en_i          = en;
    src_pxl_vld_i = vld;
    src_pxl_i     = vld ? next_pix : PW'($urandom);
    act  = m_busy && is_active(m_pos);
    e_vs = m_busy && (m_pos < VS);
    e_fd = m_busy && (m_pos == FRAME - 1);
    e_d  = (act && vld) ? next_pix : '0;
    @(posedge clk);
    #1;
    if (act && !vld) m_und = 1'b1;
    if (act && vld) next_pix = next_pix + 8'd1;
    if (m_busy) begin
      if (m_pos == FRAME - 1) begin
        m_busy = en;
        m_pos  = 0;
      end else m_pos++;
    end else if (en) begin
      m_busy = 1'b1;
      m_pos  = 0;
    end
    if (m_busy && m_pos == 0) m_und = 1'b0;
    chk("vsync", 32'(dvp_vsync_o), 32'(e_vs));
    chk("href", 32'(dvp_href_o), 32'(act));
    chk("data", 32'(dvp_d_o), 32'(e_d));
    chk("frame_done", 32'(frame_done_o), 32'(e_fd));
    chk("underrun", 32'(underrun_o), 32'(m_und));
    chk("rdy", 32'(src_pxl_rdy_o), 32'(m_busy && is_active(m_pos)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"}, 32'(src_pxl_rdy_o), 32'(0));
    chk({tag, "_vsync"}, 32'(dvp_vsync_o), 32'(0));
    chk({tag, "_href"}, 32'(dvp_href_o), 32'(0));
    chk({tag, "_data"}, 32'(dvp_d_o), 32'(0));
    chk({tag, "_done"}, 32'(frame_done_o), 32'(0));
    chk({tag, "_underrun"}, 32'(underrun_o), 32'(0));
  endtask

  task automatic reset_now();
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    m_busy = 1'b0;
    m_pos  = 0;
    m_und  = 1'b0;
    @(negedge clk);
    en_i          = 1'b0;
    src_pxl_vld_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 check_zero("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // two back-to-back frames, always valid
    for (int i = 0; i < 2*FRAME + 1; i++) cycle(1'b1, 1'b1);

    // one missing pixel on row 0, column 2
    for (int i = 0; i < FRAME; i++) cycle(1'b1, !(m_busy && m_pos == VS + VBP + 2));
    for (int i = 0; i < FRAME; i++) cycle(1'b1, 1'b1);

    // drop enable during row 1: frame finishes, then idle
    for (int i = 0; i < 2*FRAME; i++) begin
      if (m_busy && m_pos >= VS + VBP + COL + HB && m_pos < VS + VBP + 2*COL + HB) break;
      cycle(1'b1, 1'b1);
    end
    for (int i = 0; i < FRAME + 6; i++) cycle(1'b0, 1'b1);

    // random valid over ten frames, pixels held while not ready
    for (int i = 0; i < 10*FRAME + 1; i++) cycle(1'b1, 1'($urandom_range(0, 1)));

    // reset during row 0 active
    for (int i = 0; i < 2*FRAME; i++) begin
      if (m_busy && m_pos == VS + VBP + 1) break;
      cycle(1'b1, 1'b1);
    end
    reset_now();
    for (int i = 0; i < 2*FRAME + 1; i++) cycle(1'b1, 1'b1);

    // random enable and valid
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_dvp_tx.md
PIXEL_DVP_TX -- requirements
Module: pixel_dvp_tx

Interface
REQ-001 Parameter GS_PXL_W, default 8: pixel data width in bits.
REQ-002 Parameter COL_NUM, default 640: active pixels per line.
REQ-003 Parameter ROW_NUM, default 480: active lines per frame.
REQ-004 Parameter VSYNC_CYC, default 16: VSYNC pulse length in clk cycles (>=1).
REQ-005 Parameter VBP_CYC, default 32: vertical back porch length in cycles (>=1).
REQ-006 Parameter HBLK_CYC, default 144: horizontal blanking between active lines in cycles (>=1).
REQ-007 Parameter VFP_CYC, default 32: vertical front porch length in cycles (>=1).
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-high.
REQ-010 en_i  input  1  frame generation enable, sampled only at frame boundaries.
REQ-011 src_pxl_i  input  GS_PXL_W  upstream pixel data.
REQ-012 src_pxl_vld_i  input  1  upstream pixel valid.
REQ-013 src_pxl_rdy_o  output  1  pixel accepted this cycle when high together with valid.
REQ-014 dvp_vsync_o  output  1  DVP frame sync, active-high.
REQ-015 dvp_href_o  output  1  DVP line valid, active-high.
REQ-016 dvp_d_o  output  GS_PXL_W  DVP pixel data.
REQ-017 frame_done_o  output  1  one-cycle pulse at frame end.
REQ-018 underrun_o  output  1  sticky flag: a pixel was missing during the current frame.

Function
REQ-019 FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLK, VFP; one cycle counter, one row counter, widths from $clog2 of the largest count.
REQ-020 IDLE -> VSYNC when en_i=1; otherwise remain in IDLE.
REQ-021 VSYNC lasts VSYNC_CYC cycles, then VBP.
REQ-022 VBP lasts VBP_CYC cycles, then ACTIVE with row counter 0.
REQ-023 ACTIVE lasts exactly COL_NUM cycles; then HBLK if row < ROW_NUM-1, else VFP (no HBLK after last line).
REQ-024 HBLK lasts HBLK_CYC cycles, then ACTIVE with row counter incremented.
REQ-025 VFP lasts VFP_CYC cycles; on its last cycle frame_done_o is asserted for one cycle (registered, visible the cycle after that last VFP cycle); next state VSYNC if en_i=1, else IDLE.
REQ-026 Deasserting en_i mid-frame does not truncate the frame; the frame completes through VFP.
REQ-027 src_pxl_rdy_o = 1 exactly while state is ACTIVE, regardless of src_pxl_vld_i; 0 in all other states.
REQ-028 The DVP interface has no backpressure; one pixel slot is consumed every ACTIVE cycle.
REQ-029 dvp_vsync_o, dvp_href_o and dvp_d_o are registered: each equals the previous cycle's state decode (VSYNC, ACTIVE) and pixel, i.e. 1-cycle latency from acceptance to output.
REQ-030 ACTIVE cycle with src_pxl_vld_i=1: dvp_d_o takes src_pxl_i next cycle.
REQ-031 ACTIVE cycle with src_pxl_vld_i=0: dvp_d_o takes 0 next cycle, underrun_o set to 1 next cycle.
REQ-032 Outside ACTIVE, dvp_d_o is driven 0 and dvp_href_o is 0.
REQ-033 underrun_o clears on the cycle the FSM enters VSYNC; a simultaneous set and clear cannot occur (disjoint states).
REQ-034 Frame length in cycles = VSYNC_CYC + VBP_CYC + ROW_NUM*COL_NUM + (ROW_NUM-1)*HBLK_CYC + VFP_CYC.
REQ-035 Pixels presented with valid outside ACTIVE are not consumed and remain pending upstream.

Reset
REQ-036 While rst=1: state IDLE, counters 0, all outputs 0 (src_pxl_rdy_o, dvp_vsync_o, dvp_href_o, dvp_d_o, frame_done_o, underrun_o).
REQ-037 Reset asserted mid-frame aborts immediately; after release the FSM restarts from IDLE and the next frame begins with a full VSYNC.

Verification (params COL_NUM=4, ROW_NUM=2, VSYNC_CYC=2, VBP_CYC=3, HBLK_CYC=2, VFP_CYC=3)
REQ-038 en_i=1 held, source always valid with pixels 1..8 -> vsync high 2 cycles, 3 idle, href high 4 cycles (d=1,2,3,4), 2 low, href 4 cycles (d=5,6,7,8), 3 low, frame_done_o pulse, next VSYNC; frame period 18 cycles.
REQ-039 Source drops valid on 3rd pixel of row 0 -> d sequence 1,2,0,3 on row 0, underrun_o=1 from that point until next VSYNC entry, then 0.
REQ-040 en_i deasserted during row 1 -> frame completes, frame_done_o pulses, FSM enters IDLE, vsync/href stay 0, src_pxl_rdy_o=0.
REQ-041 Source valid during VBP/HBLK -> src_pxl_rdy_o=0, pixel held, consumed on first ACTIVE cycle; no pixel lost or duplicated over 10 frames (scoreboard).
REQ-042 rst pulsed during row 0 ACTIVE -> all outputs 0 same cycle; after release with en_i=1, full 2-cycle VSYNC then normal frame.
